// File: rtl/pipe_enable_ctrl.sv
// rtl/pipe_enable_ctrl.sv - valid/stall controller for a STAGES-deep chain of datapath registers
// Define PIPE_BUBBLE_COLLAPSE_EN for per-stage enables that fill bubbles while the output is stalled.
module pipe_enable_ctrl #(
  parameter int STAGES      = 4,
  parameter int COUNT_WIDTH = 3,
  parameter int STALL_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   flush,
  output logic [STAGES-1:0]      stage_en,
  output logic [STAGES-1:0]      stage_valid,
  output logic [COUNT_WIDTH-1:0] occupancy,
  output logic [STALL_WIDTH-1:0] stall_count
);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] src;
  logic              active;
  logic              in_hs;
  logic              out_hs;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  logic chain;

  // A stage may load when anything downstream of it (or itself) can make room.
  always_comb begin
    chain          = m_ready | ~valid[STAGES-1];
    en             = '0;
    en[STAGES-1]   = chain;
    for (int i = STAGES - 2; i >= 0; i--) begin
      chain = chain | ~valid[i];
      en[i] = chain;
    end
  end
`else
  always_comb begin
    en = {STAGES{m_ready | ~valid[STAGES-1]}};
  end
`endif

  always_comb begin
    src    = '0;
    src[0] = s_valid;
    for (int i = 1; i < STAGES; i++) begin
      src[i] = valid[i-1];
    end
  end

  // Reset and flush both block every handshake and freeze the datapath.
  assign active      = resetn & ~flush;
  assign s_ready     = active & en[0];
  assign m_valid     = active & valid[STAGES-1];
  assign stage_en    = active ? en : '0;
  assign stage_valid = valid;
  assign in_hs       = s_valid & s_ready;
  assign out_hs      = m_valid & m_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid       <= '0;
      occupancy   <= '0;
      stall_count <= '0;
    end else if (flush) begin
      valid       <= '0;
      occupancy   <= '0;
      stall_count <= '0;
    end else begin
      valid <= (en & src) | (~en & valid);
      if (in_hs && !out_hs) begin
        occupancy <= occupancy + COUNT_WIDTH'(1);
      end else if (out_hs && !in_hs) begin
        occupancy <= occupancy - COUNT_WIDTH'(1);
      end
      if (m_valid && !m_ready && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_WIDTH'(1);
      end
    end
  end

endmodule
